// File: rtl/func_tt_pkg.sv
// func_tt_pkg: shared state encoding and sizing for the truth-table scanner.
package func_tt_pkg;
    localparam int NUM_VECTORS = 16;
    localparam int VEC_W = 4;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/tt_settle_cnt.sv
// tt_settle_cnt: loadable down-counter flagging when a vector's settle interval has elapsed.
module tt_settle_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] init,
    output logic       expired
);
    logic [3:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= init;
        else if (en && !expired) cnt <= cnt - 4'd1;
    end
    assign expired = cnt == 4'd0;
endmodule

// File: rtl/func_tt_scanner.sv
// func_tt_scanner: walks all 16 input vectors, captures f_in and scores it against a golden table.
// Optional TT_EQUIV_CHECK_EN adds a second implementation input (fb_in) and a per-vector diff mask.
module func_tt_scanner
    import func_tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_VECTORS-1:0] expected,
    input  logic                   f_in,
`ifdef TT_EQUIV_CHECK_EN
    input  logic                   fb_in,
    output logic [NUM_VECTORS-1:0] diff_mask,
    output logic                   equiv_ok,
`endif
    output logic [VEC_W-1:0]       x,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] tt,
    output logic [4:0]             mismatch_cnt,
    output logic                   pass
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be within 1..15");
    end

    state_t                 state;
    logic [VEC_W-1:0]       idx;
    logic [NUM_VECTORS-1:0] exp_q;
    logic                   load, expired, last;
    logic [4:0]             cnt_next;

    assign last     = idx == VEC_W'(NUM_VECTORS - 1);
    assign load     = (state == IDLE && start) || (state == SAMPLE && !last);
    assign cnt_next = mismatch_cnt + 5'(f_in != exp_q[idx]);
    assign x        = idx;

`ifdef TT_EQUIV_CHECK_EN
    logic [NUM_VECTORS-1:0] diff_next;
    assign diff_next = diff_mask | (NUM_VECTORS'(f_in ^ fb_in) << idx);
`endif

    tt_settle_cnt u_settle (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .en      (state == DRIVE),
        .init    (4'(SETTLE_CYCLES - 1)),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            exp_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tt           <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
`ifdef TT_EQUIV_CHECK_EN
            diff_mask    <= '0;
            equiv_ok     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    exp_q        <= expected;
                    tt           <= '0;
                    mismatch_cnt <= '0;
                    pass         <= 1'b0;
                    idx          <= '0;
                    busy         <= 1'b1;
                    state        <= DRIVE;
`ifdef TT_EQUIV_CHECK_EN
                    diff_mask    <= '0;
                    equiv_ok     <= 1'b0;
`endif
                end
                DRIVE: if (expired) state <= SAMPLE;
                SAMPLE: begin
                    tt[idx]      <= f_in;
                    mismatch_cnt <= cnt_next;
`ifdef TT_EQUIV_CHECK_EN
                    diff_mask    <= diff_next;
                    if (last) equiv_ok <= diff_next == '0;
`endif
                    // the final verdict uses the count including this last sample
                    if (last) begin
                        pass  <= cnt_next == 5'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_func_tt_scanner.sv
// tb_func_tt_scanner: directed scans scored by a done-triggered scoreboard monitor.
module tb_func_tt_scanner;
    localparam int S = 1;
    localparam int LAT = 16 * (S + 1);

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  cnt;
        logic        pass;
        int          at;
`ifdef TT_EQUIV_CHECK_EN
        logic [15:0] diff;
        logic        eq;
`endif
    } exp_t;

    logic        clk = 0, rst = 1, start = 0, f_in, busy, done, pass;
    logic [15:0] expected = '0, tt;
    logic [3:0]  x;
    logic [4:0]  mismatch_cnt;
    int          mode = 0, cyc = 0, n_vec = 0, n_bad = 0;
    exp_t        q[$];
`ifdef TT_EQUIV_CHECK_EN
    logic        fb_in;
    logic [15:0] diff_mask;
    logic        equiv_ok;
`endif

    func_tt_scanner #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .f_in(f_in),
`ifdef TT_EQUIV_CHECK_EN
        .fb_in(fb_in), .diff_mask(diff_mask), .equiv_ok(equiv_ok),
`endif
        .x(x), .busy(busy), .done(done), .tt(tt), .mismatch_cnt(mismatch_cnt), .pass(pass)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic fmodel(logic [3:0] v, bit full);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (!a & !b & !c) | (!a & !c & d) | (a & b & !d) | (full & b & c);
    endfunction

    always_comb f_in = (mode == 1) ? 1'b1 : fmodel(x, 1'b1);
`ifdef TT_EQUIV_CHECK_EN
    always_comb fb_in = fmodel(x, 1'b0);
`endif

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic do_start(logic [15:0] e, logic [15:0] t, logic [4:0] c, bit push);
        exp_t r;
        @(negedge clk);
        expected = e;
        start = 1;
        r.tt = t; r.cnt = c; r.pass = (c == 0); r.at = cyc + 1 + LAT;
`ifdef TT_EQUIV_CHECK_EN
        r.diff = '0;
        for (int v = 0; v < 16; v++) r.diff[v] = ((mode == 1) ? 1'b1 : fmodel(4'(v), 1'b1)) ^ fmodel(4'(v), 1'b0);
        r.eq = r.diff == 0;
`endif
        if (push) q.push_back(r);
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4 * LAT; i++) begin
            @(negedge clk);
            if (done) return;
        end
        chk("done_timeout", 1, 0);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_x"}, 32'(x), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_tt"}, 32'(tt), 0);
        chk({tag, "_cnt"}, 32'(mismatch_cnt), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
    endtask

    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            if (done) begin
                if (q.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    r = q.pop_front();
                    chk("tt", 32'(tt), 32'(r.tt));
                    chk("mismatch_cnt", 32'(mismatch_cnt), 32'(r.cnt));
                    chk("pass", 32'(pass), 32'(r.pass));
                    chk("done_edge", cyc, r.at);
                    chk("busy_at_done", 32'(busy), 0);
`ifdef TT_EQUIV_CHECK_EN
                    chk("diff_mask", 32'(diff_mask), 32'(r.diff));
                    chk("equiv_ok", 32'(equiv_ok), 32'(r.eq));
`endif
                end
            end
        end
    end

    initial begin
        // reset beats a simultaneous start
        start = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        start = 0;
        chk_zero("reset");

        do_start(16'hD0E3, 16'hD0E3, 5'd0, 1);
        chk("busy_mid", 32'(busy), 1);
        wait_done();
        repeat (5) @(negedge clk);
        chk("hold_tt", 32'(tt), 32'hD0E3);
        chk("hold_pass", 32'(pass), 1);
        chk("hold_busy", 32'(busy), 0);

        do_start(16'hD0E2, 16'hD0E3, 5'd1, 1);
        wait_done();

        mode = 1;
        do_start(16'h0000, 16'hFFFF, 5'd16, 1);
        wait_done();
        mode = 0;

        do_start(16'hD0E3, 16'hD0E3, 5'd0, 1);
        repeat (3) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (6) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done();
        repeat (2 * LAT) @(negedge clk);

        do_start(16'h1234, 16'hD0E3, 5'd0, 0);
        repeat (8) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk_zero("abort");
        repeat (2 * LAT) @(negedge clk);

        do_start(16'hD0E3, 16'hD0E3, 5'd0, 1);
        wait_done();
        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
